// File: rtl/operand_stack_ctrl_if.sv
// Decoder-to-controller instruction handshake: valid/ready with opcode and immediate.
interface operand_stack_ctrl_if #(
    parameter int unsigned ST_WIDTH = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [3:0]          in_op;
    logic [ST_WIDTH-1:0] in_imm;

    modport master (output in_valid, output in_op, output in_imm, input in_ready);
    modport slave  (input in_valid, input in_op, input in_imm, output in_ready);
endinterface

// File: rtl/operand_stack_ctrl.sv
// WASM operand-stack driver: accepts stack-class instructions, tracks shadow depth,
// issues one push/pop command per legal instruction and raises a sticky trap on faults.
module operand_stack_ctrl #(
    parameter int unsigned ST_WIDTH = 32,
    parameter int unsigned ST_DEPTH = 16,
    parameter int unsigned DEPTH_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    operand_stack_ctrl_if.slave   dec,
    input  logic [3*ST_WIDTH-1:0] stk_pop_window,
    output logic                  stk_push_num,
    output logic [1:0]            stk_pop_num,
    output logic [ST_WIDTH-1:0]   stk_push_data,
    output logic [DEPTH_W-1:0]    depth,
    output logic                  retire,
    output logic                  trap,
    output logic [1:0]            trap_code
);

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_e;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_CONST  = 4'h1,
        OP_DROP   = 4'h2,
        OP_ADD    = 4'h3,
        OP_SUB    = 4'h4,
        OP_AND    = 4'h5,
        OP_OR     = 4'h6,
        OP_XOR    = 4'h7,
        OP_EQZ    = 4'h8,
        OP_EQ     = 4'h9,
        OP_LTU    = 4'hA,
        OP_SELECT = 4'hB
    } op_e;

    state_e                state_q, state_d;
    logic                  v_q, v_d;
    logic [3:0]            op_q, op_d;
    logic [ST_WIDTH-1:0]   imm_q, imm_d;
    logic [DEPTH_W-1:0]    depth_q, depth_d;
    logic                  trap_q, trap_d;
    logic [1:0]            code_q, code_d;

    logic [ST_WIDTH-1:0]   top, second, third;
    logic [1:0]            pops;
    logic                  push;
    logic                  illegal;
    logic [ST_WIDTH-1:0]   result;
    logic [DEPTH_W:0]      depth_ext, depth_new;
    logic [1:0]            fault_code;
    logic                  exec;

    assign top    = stk_pop_window[ST_WIDTH-1:0];
    assign second = stk_pop_window[2*ST_WIDTH-1:ST_WIDTH];
    assign third  = stk_pop_window[3*ST_WIDTH-1:2*ST_WIDTH];

    assign dec.in_ready = (state_q == RUN);
    assign exec         = v_q && (state_q == RUN);

    always_comb begin
        pops    = 2'd0;
        push    = 1'b0;
        illegal = 1'b0;
        result  = '0;
        case (op_q)
            OP_NOP:    ;
            OP_CONST:  begin push = 1'b1; result = imm_q; end
            OP_DROP:   pops = 2'd1;
            OP_ADD:    begin pops = 2'd2; push = 1'b1; result = second + top; end
            OP_SUB:    begin pops = 2'd2; push = 1'b1; result = second - top; end
            OP_AND:    begin pops = 2'd2; push = 1'b1; result = second & top; end
            OP_OR:     begin pops = 2'd2; push = 1'b1; result = second | top; end
            OP_XOR:    begin pops = 2'd2; push = 1'b1; result = second ^ top; end
            OP_EQZ:    begin pops = 2'd1; push = 1'b1; result = ST_WIDTH'(top == '0); end
            OP_EQ:     begin pops = 2'd2; push = 1'b1; result = ST_WIDTH'(second == top); end
            OP_LTU:    begin pops = 2'd2; push = 1'b1; result = ST_WIDTH'(second < top); end
            OP_SELECT: begin pops = 2'd3; push = 1'b1; result = (top != '0) ? third : second; end
            default:   illegal = 1'b1;
        endcase
    end

    // Overflow is only evaluated once underflow is ruled out, so depth_new never wraps.
    always_comb begin
        depth_ext  = {1'b0, depth_q};
        depth_new  = depth_ext - (DEPTH_W+1)'(pops) + (DEPTH_W+1)'(push);
        fault_code = 2'd0;
        if (illegal)
            fault_code = 2'd3;
        else if (depth_ext < (DEPTH_W+1)'(pops))
            fault_code = 2'd1;
        else if (depth_new > (DEPTH_W+1)'(ST_DEPTH-1))
            fault_code = 2'd2;
    end

    always_comb begin
        state_d       = state_q;
        v_d           = 1'b0;
        op_d          = op_q;
        imm_d         = imm_q;
        depth_d       = depth_q;
        trap_d        = trap_q;
        code_d        = code_q;
        stk_push_num  = 1'b0;
        stk_pop_num   = 2'd0;
        stk_push_data = '0;
        retire        = 1'b0;

        if (dec.in_valid && dec.in_ready) begin
            v_d   = 1'b1;
            op_d  = dec.in_op;
            imm_d = dec.in_imm;
        end

        if (exec) begin
            if (fault_code != 2'd0) begin
                state_d = TRAP;
                trap_d  = 1'b1;
                code_d  = fault_code;
                v_d     = 1'b0;
            end else begin
                stk_push_num  = push;
                stk_pop_num   = pops;
                stk_push_data = push ? result : '0;
                retire        = 1'b1;
                depth_d       = depth_new[DEPTH_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            v_q     <= 1'b0;
            op_q    <= '0;
            imm_q   <= '0;
            depth_q <= '0;
            trap_q  <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            depth_q <= depth_d;
            trap_q  <= trap_d;
            code_q  <= code_d;
        end
    end

    assign depth     = depth_q;
    assign trap      = trap_q;
    assign trap_code = code_q;

endmodule

// File: doc/operand_stack_ctrl.md
# operand_stack_ctrl

Execution-side driver of the WASM operand stack. It accepts decoded stack-class instructions over a valid/ready handshake and checks each one against a shadow occupancy counter. For each legal instruction it issues exactly one push/pop command to the operand stack, computing the push value from the stack's top-three pop window. It sits between the instruction decoder and the operand stack and raises a sticky trap on illegal opcode, underflow or overflow.

## Interface
- ST_WIDTH, 32: operand width in bits.
- ST_DEPTH, 16: stack depth; usable capacity is ST_DEPTH-1 entries (stack saturates at ST_DEPTH-1).
- DEPTH_W, 4: occupancy counter width, equal to log2(ST_DEPTH).
- clk  input  1  clock.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- in_valid  input  1  decoder has an instruction.
- in_ready  output  1  block accepts an instruction this cycle.
- in_op  input  4  opcode: 0 NOP, 1 CONST, 2 DROP, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 EQZ, 9 EQ, A LT_U, B SELECT. C-F are illegal.
- in_imm  input  ST_WIDTH  immediate, used by CONST only.
- stk_pop_window  input  3*ST_WIDTH  stack top at [W-1:0], second at [2W-1:W], third at [3W-1:2W].
- stk_push_num  output  1  push command to the stack.
- stk_pop_num  output  2  pop count, 0-3.
- stk_push_data  output  ST_WIDTH  value to push.
- depth  output  DEPTH_W  shadow stack occupancy.
- retire  output  1  one-cycle pulse per executed instruction.
- trap  output  1  sticky fault flag.
- trap_code  output  2  1 underflow, 2 overflow, 3 illegal opcode.

## Operation
- Two stages: accept register (valid, op, imm) and execute (combinational command generation).
- Accept: the handshake is in_valid && in_ready. in_ready = (state == RUN) and does not depend on in_valid.
- Pop/push per opcode:
  - NOP 0/0.
  - CONST 0/1, pushes in_imm.
  - DROP 1/0.
  - ADD, SUB, AND, OR, XOR, EQ, LT_U: 2/1.
  - EQZ 1/1.
  - SELECT 3/1.
- Operand naming: a = second, b = top.
- Results:
  - ADD: a+b. SUB: a-b. Both wrap modulo 2^ST_WIDTH.
  - AND, OR, XOR: bitwise on a and b.
  - EQZ: top==0. EQ: a==b. LT_U: a<b, unsigned. Each pushes 1 or 0, zero-extended.
  - SELECT: c=top, v2=second, v1=third; pushes (c!=0) ? v1 : v2.
- Execute-stage checks, in priority order:
  - illegal opcode → code 3.
  - depth < pops → code 1.
  - depth - pops + push > ST_DEPTH-1 → code 2.
- Legal instruction:
  - Drive stk_push_num, stk_pop_num and stk_push_data for exactly that cycle.
  - Pulse retire.
  - At the clock edge, depth <= depth - pops + push.
- Faulting instruction:
  - Drive stk_* = 0 and do not pulse retire.
  - At the clock edge: trap <= 1, trap_code <= code, state <= TRAP.
  - Any instruction accepted in the same cycle is discarded.
- Idle cycles (no valid in execute): stk_push_num=0, stk_pop_num=0, stk_push_data=0.
- FSM states:
  - RUN → TRAP on a fault.
  - TRAP is absorbing: in_ready=0 and no stack commands; it is left only by reset.
- NOP retires and does not change depth.

## Timing
- Reset values (asynchronous, immediate):
  - state RUN, accept register empty.
  - depth 0, trap 0, trap_code 0, retire 0.
  - stk_push_num 0, stk_pop_num 0, stk_push_data 0.
  - in_ready 1 while rst_n is high.
- Latency: an instruction accepted at edge N drives the stack during cycle N+1. The stack updates at edge N+2.
- Throughput: one instruction per cycle.
- Back-to-back operation needs no bypass: the stack updates at the same edge that advances the next instruction into execute, so stk_pop_window is already current.
- depth and the stack pointer change at the same edge and stay equal.
- Reset asserted mid-operation flushes the accept register. The stack resets on the same rst_n, so the two cannot diverge.
- Boundaries:
  - Depth ST_DEPTH-1 plus CONST → overflow.
  - Depth 14 plus ADD (with ST_DEPTH 16) → legal, depth becomes 13.
  - Depth 0 plus DROP → underflow.
  - An illegal opcode at depth 0 reports code 3, not 1.

## Test plan
- After reset: CONST 5, CONST 7, ADD on consecutive cycles.
  - Pushes 5, then 7, then push 12 with pop 2.
  - depth goes 1, 2, 1; retire is high for 3 cycles; window top = 12.
- CONST 3, CONST 5, SUB → 0xFFFFFFFE. Then EQZ → 0. Then EQZ again → 1. Final depth 1.
- CONST 10, CONST 20, CONST 0, SELECT → pushes 20 (pop 3, push 1), depth 1. Repeat with c=9 → pushes 10.
- From depth 0, DROP → trap=1, code 1, no stack command, in_ready low next cycle. A CONST presented in the same cycle is discarded. Stays trapped until rst_n.
- Fifteen CONSTs (reaching depth 15) then a 16th CONST → trap code 2 and depth stays 15. On a fresh run, depth 15 plus ADD retires and gives depth 14.
- Opcode 0xD at depth 0 → trap code 3. Then pulse rst_n low mid-stream → all outputs return to reset values and in_ready=1.
